llr_pe_array: RTL and testbench

Parametrised, pipelined LLR processing-element array for the polar successive-cancellation decoder, generalising the sign-processing/compare-select logic into full f/g node computation. Accepts P lanes of sign-magnitude LLR pairs per beat and returns P result LLRs. Mode is per beat: f (min-sum) or g (partial-sum-controlled add). A valid/ready elastic two-stage pipeline and a saturation event counter are included. It sits between the LLR memory read port and the LLR memory write port inside the decoder datapath.

---
 rtl/polar_pe_pkg.sv | 18 +
 rtl/llr_pe_lane.sv | 64 ++++++
 rtl/llr_pe_array.sv | 159 +++++++++++++++
 tb/tb_llr_pe_array.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/polar_pe_pkg.sv
// Shared definitions for the polar SC decoder LLR processing elements.
//   pe_mode_e  : per-beat node operation (MODE_F = min-sum, MODE_G = partial-sum add)
//   Q_DEFAULT  : default sign-magnitude LLR width
//   sm_max_mag : largest magnitude representable in a Q-bit sign-magnitude word
package polar_pe_pkg;

  typedef enum logic {
    MODE_F = 1'b0,
    MODE_G = 1'b1
  } pe_mode_e;

  localparam int unsigned Q_DEFAULT = 6;

  function automatic int unsigned sm_max_mag(input int unsigned q);
    return (32'd1 << (q - 32'd1)) - 32'd1;
  endfunction

endpackage

// File: rtl/llr_pe_lane.sv
// Per-lane combinational second stage of the LLR PE array.
// Ports:
//   i_mode    : MODE_F or MODE_G for this beat
//   i_sign_a  : effective a-sign (already folded with mode & u)
//   i_sign_b  : b-sign
//   i_mag_a/b : operand magnitudes (Q-1 bits)
//   i_borrow  : |a| < |b|, precomputed in the first stage
//   o_llr     : sign-magnitude result, zero always carries sign 0
//   o_sat     : g-mode sum clipped to the maximum magnitude
module llr_pe_lane
  import polar_pe_pkg::*;
#(
  parameter int Q = Q_DEFAULT
) (
  input  logic         i_mode,
  input  logic         i_sign_a,
  input  logic         i_sign_b,
  input  logic [Q-2:0] i_mag_a,
  input  logic [Q-2:0] i_mag_b,
  input  logic         i_borrow,
  output logic [Q-1:0] o_llr,
  output logic         o_sat
);

  localparam int M = Q - 1;
  localparam logic [M-1:0] MAX_MAG = M'(sm_max_mag(Q));

  logic [M:0]   w_sum;
  logic [M-1:0] w_diff;
  logic [M-1:0] w_mag;
  logic         w_sign;
  logic         w_sat;

  // NOTE: every signal assigned here gets a default first so no path through
  // the if/else tree leaves a value unassigned, which would infer a latch.
  always_comb begin
    w_sum  = {1'b0, i_mag_a} + {1'b0, i_mag_b};
    w_diff = i_borrow ? (i_mag_b - i_mag_a) : (i_mag_a - i_mag_b);
    w_mag  = '0;
    w_sign = 1'b0;
    w_sat  = 1'b0;
    if (i_mode == MODE_F) begin
      // Min-sum: a tie keeps |b| because borrow is strict less-than.
      w_sign = i_sign_a ^ i_sign_b;
      w_mag  = i_borrow ? i_mag_a : i_mag_b;
    end else if (i_sign_a == i_sign_b) begin
      w_sign = i_sign_b;
      if (w_sum[M]) begin
        w_mag = MAX_MAG;
        w_sat = 1'b1;
      end else begin
        w_mag = w_sum[M-1:0];
      end
    end else begin
      // Opposite signs: the larger operand dictates the sign.
      w_sign = i_borrow ? i_sign_b : i_sign_a;
      w_mag  = w_diff;
    end
  end

  assign o_llr = {w_sign & (|w_mag), w_mag};
  assign o_sat = w_sat;

endmodule

// File: rtl/llr_pe_array.sv
// Two-stage elastic array of P polar f/g processing elements.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : input beat handshake
//   mode, llr_a, llr_b, u: beat operands (u used in g mode only)
//   out_valid / out_ready: result handshake; outputs hold while stalled
//   llr_o, sat_o         : per-lane result LLRs and saturation flags
//   sat_clr, sat_cnt     : synchronous clear / saturating count of saturated lanes
module llr_pe_array
  import polar_pe_pkg::*;
#(
  parameter int Q  = Q_DEFAULT,
  parameter int P  = 4,
  parameter int CW = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           mode,
  input  logic [P*Q-1:0] llr_a,
  input  logic [P*Q-1:0] llr_b,
  input  logic [P-1:0]   u,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [P*Q-1:0] llr_o,
  output logic [P-1:0]   sat_o,
  input  logic           sat_clr,
  output logic [CW-1:0]  sat_cnt
);

  localparam int M   = Q - 1;
  localparam int PCW = $clog2(P + 1);

  // Stage 1 state
  logic           r_s1_valid;
  pe_mode_e       r_s1_mode;
  logic [P-1:0]   r_s1_sa;
  logic [P-1:0]   r_s1_sb;
  logic [P-1:0]   r_s1_borrow;
  logic [P*M-1:0] r_s1_ma;
  logic [P*M-1:0] r_s1_mb;

  // Stage 2 (output) state
  logic           r_out_valid;
  logic [P*Q-1:0] r_llr;
  logic [P-1:0]   r_sat;
  logic [CW-1:0]  r_sat_cnt;

  logic           w_s2_adv;
  logic           w_s1_adv;
  logic           w_in_fire;
  logic           w_out_fire;
  logic [P-1:0]   w_sa_eff;
  logic [P-1:0]   w_sb;
  logic [P-1:0]   w_borrow;
  logic [P*M-1:0] w_ma;
  logic [P*M-1:0] w_mb;
  logic [P*Q-1:0] w_llr;
  logic [P-1:0]   w_sat;
  logic [PCW-1:0] w_pop;
  logic [CW:0]    w_cnt_sum;

  assign w_s2_adv   = !r_out_valid || out_ready;
  assign w_s1_adv   = r_s1_valid && w_s2_adv;
  assign in_ready   = !r_s1_valid || w_s1_adv;
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = r_out_valid && out_ready;

  // Operand split; in f mode the effective a-sign equals the raw a-sign.
  always_comb begin
    w_sa_eff = '0;
    w_sb     = '0;
    w_borrow = '0;
    w_ma     = '0;
    w_mb     = '0;
    for (int i = 0; i < P; i++) begin
      w_sa_eff[i]     = llr_a[i*Q + M] ^ (mode & u[i]);
      w_sb[i]         = llr_b[i*Q + M];
      w_ma[i*M +: M]  = llr_a[i*Q +: M];
      w_mb[i*M +: M]  = llr_b[i*Q +: M];
      w_borrow[i]     = llr_a[i*Q +: M] < llr_b[i*Q +: M];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_mode   <= MODE_F;
      r_s1_sa     <= '0;
      r_s1_sb     <= '0;
      r_s1_borrow <= '0;
      r_s1_ma     <= '0;
      r_s1_mb     <= '0;
    end else begin
      if (in_ready) r_s1_valid <= in_valid;
      if (w_in_fire) begin
        r_s1_mode   <= pe_mode_e'(mode);
        r_s1_sa     <= w_sa_eff;
        r_s1_sb     <= w_sb;
        r_s1_borrow <= w_borrow;
        r_s1_ma     <= w_ma;
        r_s1_mb     <= w_mb;
      end
    end
  end

  for (genvar g = 0; g < P; g++) begin : g_lane
    llr_pe_lane #(.Q(Q)) u_lane (
      .i_mode   (r_s1_mode),
      .i_sign_a (r_s1_sa[g]),
      .i_sign_b (r_s1_sb[g]),
      .i_mag_a  (r_s1_ma[g*M +: M]),
      .i_mag_b  (r_s1_mb[g*M +: M]),
      .i_borrow (r_s1_borrow[g]),
      .o_llr    (w_llr[g*Q +: Q]),
      .o_sat    (w_sat[g])
    );
  end

  // Result data only loads when a beat moves in, so a stalled output holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_llr       <= '0;
      r_sat       <= '0;
    end else begin
      if (w_s2_adv) r_out_valid <= r_s1_valid;
      if (w_s1_adv) begin
        r_llr <= w_llr;
        r_sat <= w_sat;
      end
    end
  end

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < P; i++) w_pop = w_pop + PCW'(r_sat[i]);
    w_cnt_sum = {1'b0, r_sat_cnt} + (CW + 1)'(w_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sat_cnt <= '0;
    end else if (sat_clr) begin
      r_sat_cnt <= '0;
    end else if (w_out_fire) begin
      r_sat_cnt <= w_cnt_sum[CW] ? '1 : w_cnt_sum[CW-1:0];
    end
  end

  assign out_valid = r_out_valid;
  assign llr_o     = r_llr;
  assign sat_o     = r_sat;
  assign sat_cnt   = r_sat_cnt;

endmodule

// File: tb/tb_llr_pe_array.sv
// Directed self-checking bench for llr_pe_array (Q = 6, P = 4, CW = 16).
module tb_llr_pe_array;

  localparam int Q  = 6;
  localparam int P  = 4;
  localparam int CW = 16;

  // Sign-magnitude constants for Q = 6.
  localparam logic [Q-1:0] P0  = 6'h00;
  localparam logic [Q-1:0] N0  = 6'h20;
  localparam logic [Q-1:0] P1  = 6'h01;
  localparam logic [Q-1:0] P2  = 6'h02;
  localparam logic [Q-1:0] P5  = 6'h05;
  localparam logic [Q-1:0] N5  = 6'h25;
  localparam logic [Q-1:0] N7  = 6'h27;
  localparam logic [Q-1:0] P9  = 6'h09;
  localparam logic [Q-1:0] P12 = 6'h0C;
  localparam logic [Q-1:0] P15 = 6'h0F;
  localparam logic [Q-1:0] P20 = 6'h14;
  localparam logic [Q-1:0] P31 = 6'h1F;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic           mode;
  logic [P*Q-1:0] llr_a;
  logic [P*Q-1:0] llr_b;
  logic [P-1:0]   u;
  logic           out_valid;
  logic           out_ready;
  logic [P*Q-1:0] llr_o;
  logic [P-1:0]   sat_o;
  logic           sat_clr;
  logic [CW-1:0]  sat_cnt;

  int n_checks = 0;
  int n_errors = 0;

  llr_pe_array #(.Q(Q), .P(P), .CW(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .llr_a     (llr_a),
    .llr_b     (llr_b),
    .u         (u),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .llr_o     (llr_o),
    .sat_o     (sat_o),
    .sat_clr   (sat_clr),
    .sat_cnt   (sat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [P*Q-1:0] rep(input logic [Q-1:0] v);
    return {P{v}};
  endfunction

  // One isolated beat with out_ready high: checks acceptance, 2-cycle latency,
  // result, flags, and sat_cnt after the transfer (optionally with sat_clr).
  task automatic run_one(input string tag, input logic md,
                         input logic [P*Q-1:0] a, input logic [P*Q-1:0] b,
                         input logic [P-1:0] uu, input logic clr,
                         input logic [P*Q-1:0] exp_llr, input logic [P-1:0] exp_sat,
                         input int exp_cnt);
    @(negedge clk);
    mode = md; llr_a = a; llr_b = b; u = uu; in_valid = 1'b1; out_ready = 1'b1;
    #1 check({tag, "_in_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, "_not_yet_valid"}, out_valid, 0);
    @(posedge clk); #1;
    check({tag, "_out_valid"}, out_valid, 1);
    check({tag, "_llr"}, llr_o, exp_llr);
    check({tag, "_sat"}, sat_o, exp_sat);
    sat_clr = clr;
    @(posedge clk); #1;
    sat_clr = 1'b0;
    check({tag, "_sat_cnt"}, sat_cnt, exp_cnt);
  endtask

  initial begin
    int sent;
    int got;
    int stray;
    logic acc;

    rst_n = 1'b0; in_valid = 1'b0; mode = 1'b0; llr_a = '0; llr_b = '0;
    u = '0; out_ready = 1'b1; sat_clr = 1'b0;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_llr_o", llr_o, 0);
    check("rst_sat_o", sat_o, 0);
    check("rst_sat_cnt", sat_cnt, 0);
    @(negedge clk); rst_n = 1'b1;
    #1 check("rst_in_ready", in_ready, 1);

    // f: +12 vs -7 -> -7; g u=0 +20,+15 -> +31 clipped; g u=1 -> -5.
    run_one("f_basic", 1'b0, rep(P12), rep(N7), 4'b0000, 1'b0, rep(N7), 4'b0000, 0);
    run_one("g_sat", 1'b1, rep(P20), rep(P15), 4'b0000, 1'b0, rep(P31), 4'b1111, 4);
    run_one("g_sub", 1'b1, rep(P20), rep(P15), 4'b1111, 1'b0, rep(N5), 4'b0000, 4);
    // Zero normalisation in both modes; mixed u in f mode is ignored.
    run_one("g_zero", 1'b1, rep(P9), rep(P9), 4'b1111, 1'b0, rep(P0), 4'b0000, 4);
    run_one("f_negzero", 1'b0, rep(N0), rep(P5), 4'b1010, 1'b0, rep(P0), 4'b0000, 4);
    // f tie picks |b| with the xor sign; no saturation in f even with large operands.
    run_one("f_big", 1'b0, rep(P31), rep(P31), 4'b0000, 1'b0, rep(P31), 4'b0000, 4);

    // Backpressure: out_ready low, offer 4 beats (result +k for beat k).
    sent = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      in_valid = (sent < 4);
      mode = 1'b0; u = '0;
      llr_a = rep(Q'(sent + 1)); llr_b = rep(P31);
      #1 acc = in_valid && in_ready;
      @(posedge clk);
      if (acc) sent++;
    end
    @(negedge clk);
    check("bp_accepted", sent, 2);
    check("bp_in_ready_low", in_ready, 0);
    check("bp_hold_valid", out_valid, 1);
    check("bp_hold_llr", llr_o, rep(P1));
    got = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 20 && got < 4; c++) begin
      if (c > 0) @(negedge clk);
      in_valid = (sent < 4);
      llr_a = rep(Q'(sent + 1)); llr_b = rep(P31);
      #1 acc = in_valid && in_ready;
      if (out_valid) begin
        check("bp_order", llr_o, rep(Q'(got + 1)));
        got++;
      end
      @(posedge clk);
      if (acc) sent++;
    end
    check("bp_delivered", got, 4);
    #1 in_valid = 1'b0;
    stray = 0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid) stray++;
    end
    check("bp_no_duplicates", stray, 0);

    // sat_clr coinciding with a transfer discards that beat's saturations.
    run_one("clr", 1'b1, {P1, P1, P20, P20}, {P1, P1, P15, P15}, 4'b0000, 1'b1,
            {P2, P2, P31, P31}, 4'b0011, 0);

    // Stream 16383 four-saturation beats plus one two-saturation beat -> 65534.
    @(negedge clk);
    mode = 1'b1; u = '0; llr_a = rep(P20); llr_b = rep(P15);
    in_valid = 1'b1; out_ready = 1'b1;
    repeat (16383) @(posedge clk);
    #1 llr_a = {P1, P1, P20, P20}; llr_b = {P1, P1, P15, P15};
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 check("cnt_preload", sat_cnt, 65534);
    run_one("cnt_clip", 1'b1, {P1, P1, P20, P20}, {P1, P1, P15, P15}, 4'b0000, 1'b0,
            {P2, P2, P31, P31}, 4'b0011, 65535);

    // Reset with two beats in flight.
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; mode = 1'b0;
    llr_a = rep(P12); llr_b = rep(N7);
    @(posedge clk);
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("inflight_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_sat_cnt", sat_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    #1 check("postrst_in_ready", in_ready, 1);
    stray = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) stray++;
    end
    check("postrst_no_stale", stray, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
